// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready handshake.
// Denormals are flushed to zero on input and output; rounding is round-to-nearest-even.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         invalid
);

  localparam int unsigned M   = MAN_W + 4;  // hidden, fraction, guard, round, sticky
  localparam int unsigned SW  = MAN_W + 5;  // M plus carry
  localparam int unsigned LZW = $clog2(SW) + 1;
  localparam int unsigned EW  = EXP_W + 2;  // room for carry and negative exponents
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: unpack, classify, order by magnitude, align the smaller operand
  logic             a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic             big_sign, small_sign;
  logic [EXP_W-1:0] a_exp, b_exp, big_exp, small_exp, exp_diff;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic [M-1:0]     a_mant, b_mant, big_mant, small_mant, small_aligned;
  logic [2*M-1:0]   shift_ext;

  always_comb begin
    a_sign = a[W-1];
    a_exp  = a[W-2:MAN_W];
    a_frac = a[MAN_W-1:0];
    b_sign = b[W-1] ^ op_sub;
    b_exp  = b[W-2:MAN_W];
    b_frac = b[MAN_W-1:0];
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    a_mant = a_zero ? '0 : {1'b1, a_frac, 3'b000};
    b_mant = b_zero ? '0 : {1'b1, b_frac, 3'b000};
    swap   = {b_exp, b_mant} > {a_exp, a_mant};

    big_sign   = swap ? b_sign : a_sign;
    small_sign = swap ? a_sign : b_sign;
    big_exp    = swap ? b_exp : a_exp;
    small_exp  = swap ? a_exp : b_exp;
    big_mant   = swap ? b_mant : a_mant;
    small_mant = swap ? a_mant : b_mant;

    exp_diff  = big_exp - small_exp;
    shift_ext = {small_mant, {M{1'b0}}} >> exp_diff;
    if (exp_diff >= SHIFT_LIM) begin
      small_aligned = {{(M-1){1'b0}}, |small_mant};
    end else begin
      small_aligned = shift_ext[2*M-1:M] | {{(M-1){1'b0}}, |shift_ext[M-1:0]};
    end
  end

  logic             v1_q, nan1_q, inf1_q, inf_sign1_q, sign1_q, eff_sub1_q;
  logic [EXP_W-1:0] exp1_q;
  logic [M-1:0]     big1_q, small1_q;

  // Stage 2: magnitude add/subtract; big >= small so the difference never goes negative
  logic [SW-1:0] sum_d;
  assign sum_d = eff_sub1_q ? {1'b0, big1_q} - {1'b0, small1_q}
                            : {1'b0, big1_q} + {1'b0, small1_q};

  logic             v2_q, nan2_q, inf2_q, inf_sign2_q, sign2_q, eff_sub2_q;
  logic [EXP_W-1:0] exp2_q;
  logic [SW-1:0]    sum2_q;

  // Stage 3: normalise, round, pack and resolve special values
  logic [LZW-1:0] lz;
  logic           found, inc, flush;
  logic [M-1:0]   norm;
  logic [EW-1:0]  exp_n, exp_r;
  logic [MAN_W:0] rnd;
  logic [MAN_W-1:0] frac_o;
  logic [W-1:0]   res_d;
  logic           ovf_d, inv_d;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = M - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum2_q[i]) found = 1'b1;
        else           lz = lz + 1'b1;
      end
    end

    if (sum2_q[SW-1]) begin
      norm  = {sum2_q[SW-1:2], sum2_q[1] | sum2_q[0]};
      exp_n = {2'b00, exp2_q} + 1'b1;
    end else begin
      norm  = sum2_q[M-1:0] << lz;
      exp_n = {2'b00, exp2_q} - EW'(lz);
    end
    flush = exp_n[EW-1] || (exp_n == '0);

    inc    = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd    = {1'b0, norm[M-2:3]} + (MAN_W+1)'(inc);
    frac_o = rnd[MAN_W-1:0];
    exp_r  = exp_n;
    if (rnd[MAN_W]) begin
      exp_r  = exp_n + 1'b1;
      frac_o = '0;
    end

    res_d = '0;
    ovf_d = 1'b0;
    inv_d = 1'b0;
    if (v2_q) begin
      if (nan2_q) begin
        res_d = QNAN;
        inv_d = 1'b1;
      end else if (inf2_q) begin
        res_d = {inf_sign2_q, EXP_ONES, {MAN_W{1'b0}}};
      end else if (!norm[M-1]) begin
        // exact zero: like-signed zeros keep their sign, cancellation gives +0
        res_d = {sign2_q & !eff_sub2_q, {(W-1){1'b0}}};
      end else if (flush) begin
        res_d = {sign2_q, {(W-1){1'b0}}};
      end else if (exp_r >= {2'b00, EXP_ONES}) begin
        res_d = {sign2_q, EXP_ONES, {MAN_W{1'b0}}};
        ovf_d = 1'b1;
      end else begin
        res_d = {sign2_q, exp_r[EXP_W-1:0], frac_o};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      nan1_q      <= 1'b0;
      inf1_q      <= 1'b0;
      inf_sign1_q <= 1'b0;
      sign1_q     <= 1'b0;
      eff_sub1_q  <= 1'b0;
      exp1_q      <= '0;
      big1_q      <= '0;
      small1_q    <= '0;
      v2_q        <= 1'b0;
      nan2_q      <= 1'b0;
      inf2_q      <= 1'b0;
      inf_sign2_q <= 1'b0;
      sign2_q     <= 1'b0;
      eff_sub2_q  <= 1'b0;
      exp2_q      <= '0;
      sum2_q      <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      invalid     <= 1'b0;
    end else if (advance) begin
      v1_q        <= in_valid;
      nan1_q      <= a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign));
      inf1_q      <= a_inf || b_inf;
      inf_sign1_q <= a_inf ? a_sign : b_sign;
      sign1_q     <= big_sign;
      eff_sub1_q  <= big_sign ^ small_sign;
      exp1_q      <= big_exp;
      big1_q      <= big_mant;
      small1_q    <= small_aligned;
      v2_q        <= v1_q;
      nan2_q      <= nan1_q;
      inf2_q      <= inf1_q;
      inf_sign2_q <= inf_sign1_q;
      sign2_q     <= sign1_q;
      eff_sub2_q  <= eff_sub1_q;
      exp2_q      <= exp1_q;
      sum2_q      <= sum_d;
      out_valid   <= v2_q;
      result      <= res_d;
      overflow    <= ovf_d;
      invalid     <= inv_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed corner cases plus randomized operands checked
// against an exact wide-integer reference model, with backpressure and mid-stream reset.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready, overflow, invalid;
  logic [31:0] a, b, result;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Exact reference: operands become integers in units of 2^-149, summed exactly, then rounded.
  function automatic logic [33:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic sub);
    logic         sx, sy, s, g, st;
    int           ex, ey, e, p;
    logic [22:0]  fx, fy;
    logic [319:0] vx, vy, mag, mask;
    logic [24:0]  keep;
    sx = x[31];
    ex = int'(x[30:23]);
    fx = x[22:0];
    sy = y[31] ^ sub;
    ey = int'(y[30:23]);
    fy = y[22:0];
    if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0) || (ex == 255 && ey == 255 && sx != sy))
      return {32'h7FC00000, 2'b01};
    if (ex == 255) return {sx, 8'hFF, 23'h0, 2'b00};
    if (ey == 255) return {sy, 8'hFF, 23'h0, 2'b00};
    vx = (ex == 0) ? '0 : (320'({1'b1, fx}) << (ex - 1));
    vy = (ey == 0) ? '0 : (320'({1'b1, fy}) << (ey - 1));
    if (sx == sy) begin
      mag = vx + vy;
      s   = sx;
    end else if (vx >= vy) begin
      mag = vx - vy;
      s   = sx;
    end else begin
      mag = vy - vx;
      s   = sy;
    end
    if (mag == '0) return {(sx == sy) ? sx : 1'b0, 31'h0, 2'b00};
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) return {s, 31'h0, 2'b00};
    keep = 25'(mag >> (p - 23));
    g    = (p >= 24) ? mag[p - 24] : 1'b0;
    st   = 1'b0;
    if (p >= 25) begin
      mask = (320'(1) << (p - 24)) - 320'(1);
      st   = |(mag & mask);
    end
    if (g && (st || keep[0])) keep = keep + 25'd1;
    if (keep[24]) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 2'b10};
    return {s, 8'(e), keep[22:0], 2'b00};
  endfunction

  function automatic logic [31:0] rand_fp(input int near);
    int          sel, e;
    logic [22:0] f;
    sel = int'($urandom_range(0, 15));
    f   = 23'($urandom);
    if ($urandom_range(0, 3) == 0) f = {f[22:19], 19'h0};
    if (near >= 0 && sel < 8) begin
      e = near + int'($urandom_range(0, 4)) - 2;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
    end else if (sel == 8) e = 0;
    else if (sel == 9) begin
      e = 255;
      if ($urandom_range(0, 1) == 0) f = '0;
    end else if (sel == 10) e = 254;
    else e = int'($urandom_range(1, 254));
    return {1'($urandom), 8'(e), f};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                       input logic [33:0] want);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    op_sub   = xs;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    if (acc) exp_q.push_back(want);
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0, required 1");
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic issue_rand();
    logic [31:0] xa, xb;
    logic        xs;
    xa = rand_fp(-1);
    xb = rand_fp(int'(xa[30:23]));
    if ($urandom_range(0, 7) == 0) xb = {1'($urandom), xa[30:0]};
    xs = 1'($urandom);
    issue(xa, xb, xs, ref_model(xa, xb, xs));
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) sync();
    check("drain_queue_empty", 40'(exp_q.size()), 40'(0));
  endtask

  // Monitor: pops on every output transfer, checks hold-while-stalled and idle flags.
  logic        hold_pending = 1'b0;
  logic [33:0] held;
  logic [33:0] want_m;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) hold_pending = 1'b0;
      else begin
        if (hold_pending)
          check("hold_stable", 40'({out_valid, result, overflow, invalid}), 40'({1'b1, held}));
        if (!out_valid) check("idle_flags", 40'({overflow, invalid}), 40'(0));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %h, expected no output", result);
          end else begin
            want_m = exp_q.pop_front();
            check("result", 40'({result, overflow, invalid}), 40'(want_m));
            n_out++;
          end
        end
        hold_pending = out_valid && !out_ready;
        held         = {result, overflow, invalid};
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] d_a [13] = '{32'h3F800000, 32'h80000000, 32'h7F7FFFFF, 32'h7F800000,
                            32'h7FC00001, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                            32'h7F800000, 32'h3F800000, 32'h00000000, 32'h00000001,
                            32'h00000000};
  logic [31:0] d_b [13] = '{32'h3F800000, 32'h80000000, 32'h7F7FFFFF, 32'h7F800000,
                            32'h3F800000, 32'h33800000, 32'h34400000, 32'h33800000,
                            32'h3F800000, 32'h7F800000, 32'h00000000, 32'h3F800000,
                            32'h80000000};
  logic        d_s [13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b0};
  logic [33:0] d_e [13] = '{{32'h00000000, 2'b00}, {32'h80000000, 2'b00},
                            {32'h7F800000, 2'b10}, {32'h7FC00000, 2'b01},
                            {32'h7FC00000, 2'b01}, {32'h3F800000, 2'b00},
                            {32'h3F800002, 2'b00}, {32'h3F7FFFFF, 2'b00},
                            {32'h7F800000, 2'b00}, {32'hFF800000, 2'b00},
                            {32'h00000000, 2'b00}, {32'h3F800000, 2'b00},
                            {32'h00000000, 2'b00}};

  int   cyc, out_before;
  logic seen;
  bit   rand_done;

  initial begin : main
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 40'(out_valid), 40'(0));
    check("reset_result", 40'(result), 40'(0));
    check("reset_flags", 40'({overflow, invalid}), 40'(0));
    check("reset_in_ready", 40'(in_ready), 40'(1));
    rst_n = 1'b1;
    sync();

    // Latency on an empty pipeline, counting the accepting edge as cycle 1
    issue(32'h3F800000, 32'h40000000, 1'b0, {32'h40400000, 2'b00});
    cyc  = 1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    check("latency", 40'(cyc), 40'(3));
    sync();

    for (int i = 0; i < 13; i++) issue(d_a[i], d_b[i], d_s[i], d_e[i]);
    wait_drain();

    // 8 back-to-back ops with a 4-cycle output stall in the middle
    out_before = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) issue_rand();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("stall_in_ready", 40'(in_ready), 40'(0));
          check("stall_out_valid", 40'(out_valid), 40'(1));
          sync();
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stream_count", 40'(n_out - out_before), 40'(8));

    // Random operands under random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) issue_rand();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          sync();
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Asynchronous reset with operations in flight
    for (int i = 0; i < 3; i++) issue_rand();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 40'(out_valid), 40'(0));
    check("midreset_result", 40'(result), 40'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) sync();
    check("post_reset_idle", 40'(out_valid), 40'(0));
    issue(32'h3F800000, 32'h40000000, 1'b1, {32'hBF800000, 2'b00});
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
